// File: rtl/riscv_csr_port_arbiter_pkg.sv
// Shared CSR-port definitions: op encodings (matching riscv_defines), DIFT CSR addresses
// and the request bundle carried from each requester to the CSR file.
package riscv_csr_port_arbiter_pkg;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [11:0] CSR_ADDR_TPR = 12'h700;
  localparam logic [11:0] CSR_ADDR_TCR = 12'h701;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  op;
  } csr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CORE = 2'b01,
    GNT_DBG  = 2'b10
  } gnt_e;

  // TPR/TCR hold the DIFT policy and are frozen against the core while locked.
  function automatic logic is_dift_csr(input logic [11:0] addr);
    return (addr == CSR_ADDR_TPR) || (addr == CSR_ADDR_TCR);
  endfunction

endpackage

// File: rtl/riscv_csr_port_arbiter.sv
// Arbitrates the single CSR-file port between the ID stage and the debug unit, bounding
// debug starvation with a core-grant streak counter and enforcing the DIFT policy lock.
module riscv_csr_port_arbiter
  import riscv_csr_port_arbiter_pkg::*;
#(
  parameter int MAX_CORE_STREAK = 4,
  parameter int STREAK_W        = $clog2(MAX_CORE_STREAK + 1)
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        core_req_i,
  input  logic [11:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [1:0]  core_op_i,
  output logic        core_gnt_o,
  output logic [31:0] core_rdata_o,
  output logic        core_lock_err_o,

  input  logic        dbg_req_i,
  input  logic [11:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  input  logic [1:0]  dbg_op_i,
  input  logic        dbg_halt_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,

  input  logic        dift_lock_i,

  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CORE_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                dbg_rvalid_q;
  logic [31:0]         dbg_rdata_q, dbg_rdata_d;
  logic                lock_err_q;

  gnt_e     gnt;
  logic     streak_sat;
  logic     lock_hit;
  csr_req_t core_bus, dbg_bus, sel_bus;

  assign core_bus   = '{addr: core_addr_i, wdata: core_wdata_i, op: core_op_i};
  assign dbg_bus    = '{addr: dbg_addr_i,  wdata: dbg_wdata_i,  op: dbg_op_i};
  assign streak_sat = (streak_q == STREAK_MAX);

  // Debug wins when halted, when uncontested, or once the core has used up its streak.
  always_comb begin
    gnt = GNT_NONE;
    if (rst_n) begin
      if (dbg_req_i && (dbg_halt_i || !core_req_i || streak_sat)) gnt = GNT_DBG;
      else if (core_req_i)                                        gnt = GNT_CORE;
    end
  end

  assign core_gnt_o = (gnt == GNT_CORE);
  assign dbg_gnt_o  = (gnt == GNT_DBG);

  // The core still completes a locked access (no stall); only its side effect is dropped.
  assign lock_hit = core_gnt_o && dift_lock_i && is_dift_csr(core_addr_i)
                    && (core_op_i != CSR_OP_NONE);

  always_comb begin
    sel_bus = '{addr: 12'h000, wdata: 32'h0, op: CSR_OP_NONE};
    case (gnt)
      GNT_CORE: begin
        sel_bus = core_bus;
        if (lock_hit) sel_bus.op = CSR_OP_NONE;
      end
      GNT_DBG:  sel_bus = dbg_bus;
      default:  ;
    endcase
  end

  assign csr_access_o = core_gnt_o || dbg_gnt_o;
  assign csr_addr_o   = sel_bus.addr;
  assign csr_wdata_o  = sel_bus.wdata;
  assign csr_op_o     = sel_bus.op;
  assign core_rdata_o = csr_rdata_i;

  always_comb begin
    streak_d = streak_q;
    if (dbg_gnt_o || !dbg_req_i)      streak_d = '0;
    else if (core_gnt_o && !streak_sat) streak_d = streak_q + STREAK_W'(1);
  end

  assign dbg_rdata_d = dbg_gnt_o ? csr_rdata_i : dbg_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q     <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= 32'h0;
      lock_err_q   <= 1'b0;
    end else begin
      streak_q     <= streak_d;
      dbg_rvalid_q <= dbg_gnt_o;
      dbg_rdata_q  <= dbg_rdata_d;
      lock_err_q   <= lock_hit;
    end
  end

  assign dbg_rvalid_o    = dbg_rvalid_q;
  assign dbg_rdata_o     = dbg_rdata_q;
  assign core_lock_err_o = lock_err_q;

endmodule

// File: tb/tb_riscv_csr_port_arbiter.sv
// Self-checking bench for riscv_csr_port_arbiter: directed vector table, hand-written
// starvation/reset sequences, and a randomized run against a behavioural model.
module tb_riscv_csr_port_arbiter;
  localparam int MAX = 4;
  localparam logic [1:0] ON = 2'b00, OW = 2'b01, OS = 2'b10, OC = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_i, dbg_req_i, dbg_halt_i, dift_lock_i;
  logic [11:0] core_addr_i, dbg_addr_i;
  logic [31:0] core_wdata_i, dbg_wdata_i, csr_rdata_i;
  logic [1:0]  core_op_i, dbg_op_i;
  logic        core_gnt_o, core_lock_err_o, dbg_gnt_o, dbg_rvalid_o, csr_access_o;
  logic [31:0] core_rdata_o, dbg_rdata_o, csr_wdata_o;
  logic [11:0] csr_addr_o;
  logic [1:0]  csr_op_o;

  int checks = 0;
  int errors = 0;

  riscv_csr_port_arbiter #(.MAX_CORE_STREAK(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_op_i(core_op_i), .core_gnt_o(core_gnt_o), .core_rdata_o(core_rdata_o),
    .core_lock_err_o(core_lock_err_o),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_op_i(dbg_op_i), .dbg_halt_i(dbg_halt_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .dift_lock_i(dift_lock_i),
    .csr_access_o(csr_access_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .csr_op_o(csr_op_o), .csr_rdata_i(csr_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic creq; logic [11:0] caddr; logic [31:0] cwd; logic [1:0] cop;
    logic dreq; logic [11:0] daddr; logic [31:0] dwd; logic [1:0] dop;
    logic halt; logic lock; logic [31:0] rd;
    logic e_cg; logic e_dg; logic [1:0] e_op; logic [11:0] e_addr; logic [31:0] e_wd;
    logic e_rv; logic e_le;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic creq, input logic [11:0] caddr,
                       input logic [31:0] cwd, input logic [1:0] cop, input logic dreq,
                       input logic [11:0] daddr, input logic [31:0] dwd, input logic [1:0] dop,
                       input logic halt, input logic lock, input logic [31:0] rd);
    rst_n = r; core_req_i = creq; core_addr_i = caddr; core_wdata_i = cwd; core_op_i = cop;
    dbg_req_i = dreq; dbg_addr_i = daddr; dbg_wdata_i = dwd; dbg_op_i = dop;
    dbg_halt_i = halt; dift_lock_i = lock; csr_rdata_i = rd;
  endtask

  task automatic chk_comb(input string nm, input logic cg, input logic dg, input logic [1:0] op,
                          input logic [11:0] addr, input logic [31:0] wd);
    chk({nm, ".core_gnt"}, 32'(core_gnt_o), 32'(cg));
    chk({nm, ".dbg_gnt"}, 32'(dbg_gnt_o), 32'(dg));
    chk({nm, ".access"}, 32'(csr_access_o), 32'(cg | dg));
    chk({nm, ".op"}, 32'(csr_op_o), 32'(op));
    chk({nm, ".addr"}, 32'(csr_addr_o), 32'(addr));
    chk({nm, ".wdata"}, csr_wdata_o, wd);
    if (cg) chk({nm, ".core_rdata"}, core_rdata_o, csr_rdata_i);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Behavioural model state for the random phase.
  int          m_streak;
  logic        m_rv, m_le;
  logic [31:0] m_rd;
  int          dwait;

  vec_t vt[11];

  initial begin
    drive(1'b0, 1'b1, 12'h341, 32'h1, OW, 1'b1, 12'h300, 32'h2, OW, 1'b0, 1'b0, 32'hdead);
    #1; #4;
    chk_comb("rst_comb", 1'b0, 1'b0, ON, 12'h0, 32'h0);
    tick(); tick();
    chk("rst.rvalid", 32'(dbg_rvalid_o), 32'h0);
    chk("rst.rdata", dbg_rdata_o, 32'h0);
    chk("rst.lock_err", 32'(core_lock_err_o), 32'h0);

    //         creq caddr   cwd        cop dreq daddr   dwd       dop halt lock rd      cg dg op  addr    wd         rv le
    vt[0]  = '{1'b1,12'h341,32'h1234,  OW, 1'b0,12'h000,32'h0,    ON, 1'b0,1'b0,32'h55, 1'b1,1'b0,OW,12'h341,32'h1234,1'b0,1'b0};
    vt[1]  = '{1'b0,12'h000,32'h0,     ON, 1'b1,12'h300,32'h0,    ON, 1'b0,1'b0,32'h7,  1'b0,1'b1,ON,12'h300,32'h0,   1'b1,1'b0};
    vt[2]  = '{1'b1,12'h342,32'haa,    OW, 1'b1,12'h305,32'hbb,   OS, 1'b0,1'b0,32'h8,  1'b1,1'b0,OW,12'h342,32'haa,  1'b0,1'b0};
    vt[3]  = '{1'b1,12'h342,32'haa,    OW, 1'b1,12'h306,32'hcc,   OC, 1'b1,1'b0,32'h9,  1'b0,1'b1,OC,12'h306,32'hcc,  1'b1,1'b0};
    vt[4]  = '{1'b0,12'h123,32'h5,     OW, 1'b0,12'h456,32'h6,    OW, 1'b0,1'b0,32'h1,  1'b0,1'b0,ON,12'h000,32'h0,   1'b0,1'b0};
    vt[5]  = '{1'b1,12'h700,32'hf0,    OW, 1'b0,12'h000,32'h0,    ON, 1'b0,1'b1,32'h11, 1'b1,1'b0,ON,12'h700,32'hf0,  1'b0,1'b1};
    vt[6]  = '{1'b1,12'h701,32'h0,     ON, 1'b0,12'h000,32'h0,    ON, 1'b0,1'b1,32'h12, 1'b1,1'b0,ON,12'h701,32'h0,   1'b0,1'b0};
    vt[7]  = '{1'b0,12'h000,32'h0,     ON, 1'b1,12'h700,32'hab,   OW, 1'b0,1'b1,32'h3,  1'b0,1'b1,OW,12'h700,32'hab,  1'b1,1'b0};
    vt[8]  = '{1'b1,12'h702,32'h4,     OS, 1'b0,12'h000,32'h0,    ON, 1'b0,1'b1,32'h13, 1'b1,1'b0,OS,12'h702,32'h4,   1'b0,1'b0};
    vt[9]  = '{1'b1,12'h701,32'h5,     OW, 1'b0,12'h000,32'h0,    ON, 1'b0,1'b0,32'h14, 1'b1,1'b0,OW,12'h701,32'h5,   1'b0,1'b0};
    vt[10] = '{1'b1,12'h701,32'h6,     OC, 1'b0,12'h000,32'h0,    ON, 1'b0,1'b1,32'h15, 1'b1,1'b0,ON,12'h701,32'h6,   1'b0,1'b1};

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vt[i].creq, vt[i].caddr, vt[i].cwd, vt[i].cop, vt[i].dreq, vt[i].daddr,
            vt[i].dwd, vt[i].dop, vt[i].halt, vt[i].lock, vt[i].rd);
      #4;
      chk_comb($sformatf("vec%0d", i), vt[i].e_cg, vt[i].e_dg, vt[i].e_op, vt[i].e_addr, vt[i].e_wd);
      tick();
      chk($sformatf("vec%0d.rvalid", i), 32'(dbg_rvalid_o), 32'(vt[i].e_rv));
      chk($sformatf("vec%0d.lock_err", i), 32'(core_lock_err_o), 32'(vt[i].e_le));
      if (vt[i].e_rv) chk($sformatf("vec%0d.dbg_rdata", i), dbg_rdata_o, vt[i].rd);
    end

    // Starvation: both held, debug gets every fifth slot.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 12'h340, 32'(i), OS, 1'b1, 12'h7b0, 32'h99, ON, 1'b0, 1'b0, 32'(i + 100));
      #4;
      chk($sformatf("starve%0d.core_gnt", i), 32'(core_gnt_o), 32'((i % 5) != 4));
      chk($sformatf("starve%0d.dbg_gnt", i), 32'(dbg_gnt_o), 32'((i % 5) == 4));
      tick();
    end

    // Reset one cycle after a debug grant drops the pending read data.
    drive(1'b1, 1'b0, 12'h0, 32'h0, ON, 1'b1, 12'h300, 32'h0, ON, 1'b0, 1'b0, 32'h77);
    #4; chk("rstmid.dbg_gnt", 32'(dbg_gnt_o), 32'h1);
    tick();
    drive(1'b0, 1'b1, 12'h341, 32'h1, OW, 1'b1, 12'h300, 32'h0, OW, 1'b1, 1'b0, 32'h88);
    #4; chk_comb("rstmid_comb", 1'b0, 1'b0, ON, 12'h0, 32'h0);
    tick();
    chk("rstmid.rvalid", 32'(dbg_rvalid_o), 32'h0);
    chk("rstmid.rdata", dbg_rdata_o, 32'h0);

    // Reset in the middle of a core streak restarts the full streak.
    drive(1'b1, 1'b1, 12'h341, 32'h1, OW, 1'b1, 12'h300, 32'h0, ON, 1'b0, 1'b0, 32'h1);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk($sformatf("rststreak%0d.core_gnt", i), 32'(core_gnt_o), 32'(i != 4));
      chk($sformatf("rststreak%0d.dbg_gnt", i), 32'(dbg_gnt_o), 32'(i == 4));
      tick();
    end

    // Randomized run against the model; model starts from a clean reset.
    rst_n = 1'b0; dbg_req_i = 1'b0; tick();
    m_streak = 0; m_rv = 1'b0; m_rd = 32'h0; m_le = 1'b0; dwait = 0;
    for (int c = 0; c < 3000; c++) begin
      logic e_dg, e_cg, hit;
      logic [1:0] e_op; logic [11:0] e_addr; logic [31:0] e_wd;
      rst_n = ($urandom_range(0, 99) != 0);
      core_req_i  = $urandom_range(0, 2) != 0;
      core_addr_i = ($urandom_range(0, 1) != 0) ? 12'(12'h700 + $urandom_range(0, 2)) : 12'($urandom);
      core_wdata_i = $urandom; core_op_i = 2'($urandom);
      // A debug request holds its payload until granted.
      if (!(dbg_req_i && dwait > 0)) begin
        dbg_req_i = $urandom_range(0, 2) == 0;
        dbg_addr_i = 12'($urandom); dbg_wdata_i = $urandom; dbg_op_i = 2'($urandom);
      end
      dbg_halt_i  = $urandom_range(0, 7) == 0;
      dift_lock_i = $urandom_range(0, 1) != 0;
      csr_rdata_i = $urandom;

      e_dg = rst_n && dbg_req_i && (dbg_halt_i || !core_req_i || m_streak == MAX);
      e_cg = rst_n && core_req_i && !e_dg;
      hit  = e_cg && dift_lock_i && (core_addr_i == 12'h700 || core_addr_i == 12'h701)
             && core_op_i != ON;
      e_op = e_dg ? dbg_op_i : (e_cg && !hit) ? core_op_i : ON;
      e_addr = e_dg ? dbg_addr_i : e_cg ? core_addr_i : 12'h0;
      e_wd   = e_dg ? dbg_wdata_i : e_cg ? core_wdata_i : 32'h0;
      #4;
      chk_comb($sformatf("rnd%0d", c), e_cg, e_dg, e_op, e_addr, e_wd);
      if (e_dg) begin
        chk($sformatf("rnd%0d.dbg_wait", c), 32'(dwait <= MAX), 32'h1);
        dwait = 0;
      end else if (rst_n && dbg_req_i) dwait++;
      else dwait = 0;

      if (!rst_n) begin
        m_streak = 0; m_rv = 1'b0; m_rd = 32'h0; m_le = 1'b0; dbg_req_i = 1'b0;
      end else begin
        m_rv = e_dg; m_le = hit;
        if (e_dg) m_rd = csr_rdata_i;
        if (e_dg || !dbg_req_i) m_streak = 0;
        else if (e_cg && m_streak < MAX) m_streak++;
      end
      tick();
      chk($sformatf("rnd%0d.rvalid", c), 32'(dbg_rvalid_o), 32'(m_rv));
      chk($sformatf("rnd%0d.rdata", c), dbg_rdata_o, m_rd);
      chk($sformatf("rnd%0d.lock_err", c), 32'(core_lock_err_o), 32'(m_le));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
